// File: rtl/counter_pkg.sv
// counter_pkg: shared types, mode encodings and next-count function for the up/down counter
package counter_pkg;

    typedef enum logic [0:0] {
        S_TRACK = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // Callers truncate the result to their own counter width, which gives the modulo wrap.
    function automatic logic [31:0] nxt_count(input logic [31:0] c, input logic m);
        return (m == MODE_DOWN) ? c - 32'd1 : c + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and increment enable
module sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] cnt
);

    // Clear wins; otherwise count up and hold once all-ones is reached.
    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/counter_seq_checker.sv
// counter_seq_checker: passive monitor predicting the up/down counter sequence and flagging mismatches
module counter_seq_checker
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int ERR_W   = 8,
    parameter int MAX_ERR = 4,
    parameter int RESYNC  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] chk_count,
    output logic [WIDTH-1:0] first_got,
    output logic [WIDTH-1:0] first_exp,
    output logic             halted
);

    state_t           state;
    logic             track;
    logic             miss;
    logic             to_halt;
    logic [ERR_W-1:0] err_next;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] next_exp;

    assign track    = state == S_TRACK;
    // Case inequality so an X/Z sample is reported rather than silently passing.
    assign miss     = count !== expected;
    assign err_next = (err_count == '1) ? err_count : err_count + 1'b1;
    assign to_halt  = (MAX_ERR != 0) && miss && (int'(err_next) == MAX_ERR);
    assign base     = (RESYNC != 0) ? count : expected;
    assign next_exp = WIDTH'(nxt_count(32'(base), mode));
    assign halted   = state == S_HALT;

    // Compare, predict, record the first failure and move to halt once the error budget is spent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_TRACK;
            expected   <= '0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            first_got  <= '0;
            first_exp  <= '0;
        end else if (track) begin
            expected <= next_exp;
            mismatch <= miss;
            state    <= to_halt ? S_HALT : S_TRACK;
            if (miss && !err_sticky) begin
                first_got  <= count;
                first_exp  <= expected;
                err_sticky <= 1'b1;
            end
        end else begin
            mismatch <= 1'b0;
        end
    end

    sat_counter #(.ERR_W(ERR_W)) u_err (
        .clk(clk),
        .clr(reset),
        .inc(track && miss),
        .cnt(err_count)
    );

    sat_counter #(.ERR_W(ERR_W)) u_chk (
        .clk(clk),
        .clr(reset),
        .inc(track),
        .cnt(chk_count)
    );

endmodule

// File: tb/tb_counter_seq_checker.sv
// tb_counter_seq_checker: table-driven check of the counter sequence monitor
module tb_counter_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode = 1'b0;
    logic [2:0] count = 3'd0;

    logic [2:0] a_exp, a_fg, a_fe;
    logic       a_mis, a_stk, a_hlt;
    logic [7:0] a_err, a_chk;

    logic [2:0] b_exp, b_fg, b_fe;
    logic       b_mis, b_stk, b_hlt;
    logic [1:0] b_err, b_chk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic       md;
        logic [2:0] cnt;
        logic       mis;
        logic [2:0] ex;
        int         err;
        int         chk;
        logic       stk;
        logic       hlt;
        logic [2:0] fg;
        logic [2:0] fe;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    counter_seq_checker #(.WIDTH(3), .ERR_W(8), .MAX_ERR(4), .RESYNC(1)) dut_a (
        .clk(clk), .reset(reset), .mode(mode), .count(count),
        .expected(a_exp), .mismatch(a_mis), .err_sticky(a_stk),
        .err_count(a_err), .chk_count(a_chk), .first_got(a_fg),
        .first_exp(a_fe), .halted(a_hlt)
    );

    counter_seq_checker #(.WIDTH(3), .ERR_W(2), .MAX_ERR(0), .RESYNC(1)) dut_b (
        .clk(clk), .reset(reset), .mode(mode), .count(count),
        .expected(b_exp), .mismatch(b_mis), .err_sticky(b_stk),
        .err_count(b_err), .chk_count(b_chk), .first_got(b_fg),
        .first_exp(b_fe), .halted(b_hlt)
    );

    task automatic check(input string name, input int idx, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d want %0d", name, idx, got, want);
        end
    endtask

    task automatic v(input logic rst, input logic md, input logic [2:0] cnt,
                     input logic mis, input logic [2:0] ex, input int err, input int chk,
                     input logic stk, input logic hlt, input logic [2:0] fg, input logic [2:0] fe);
        vq.push_back('{rst, md, cnt, mis, ex, err, chk, stk, hlt, fg, fe});
    endtask

    task automatic step(input logic rst, input logic md, input logic [2:0] cnt);
        reset = rst;
        mode  = md;
        count = cnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, then a correct up count through the wrap
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            v(0, 0, 3'(i), 0, 3'(i + 1), 0, i + 1, 0, 0, 0, 0);
        // down immediately after reset, wrapping 0 -> 7
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 7, 0, 1, 0, 0, 0, 0);
        v(0, 1, 7, 0, 6, 0, 2, 0, 0, 0, 0);
        v(0, 1, 6, 0, 5, 0, 3, 0, 0, 0, 0);
        v(0, 1, 5, 0, 4, 0, 4, 0, 0, 0, 0);
        // up then down: mode takes effect on the same edge
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            v(0, 0, 3'(i), 0, 3'(i + 1), 0, i + 1, 0, 0, 0, 0);
        v(0, 1, 5, 0, 4, 0, 6, 0, 0, 0, 0);
        v(0, 1, 4, 0, 3, 0, 7, 0, 0, 0, 0);
        v(0, 1, 3, 0, 2, 0, 8, 0, 0, 0, 0);
        // single injected error, resync afterwards
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        v(0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0);
        v(0, 0, 2, 0, 3, 0, 3, 0, 0, 0, 0);
        v(0, 0, 5, 1, 6, 1, 4, 1, 0, 5, 3);
        v(0, 0, 6, 0, 7, 1, 5, 1, 0, 5, 3);
        v(0, 0, 7, 0, 0, 1, 6, 1, 0, 5, 3);
        // stuck count: halt on the fourth mismatch, then frozen
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(0, 0, 2, 1, 3, 1, 1, 1, 0, 2, 0);
        v(0, 0, 2, 1, 3, 2, 2, 1, 0, 2, 0);
        v(0, 0, 2, 1, 3, 3, 3, 1, 0, 2, 0);
        v(0, 0, 2, 1, 3, 4, 4, 1, 1, 2, 0);
        v(0, 0, 2, 0, 3, 4, 4, 1, 1, 2, 0);
        v(0, 0, 2, 0, 3, 4, 4, 1, 1, 2, 0);
        // reset leaves halt and checking resumes
        v(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].md, vq[i].cnt);
            check("mismatch",   i, int'(a_mis), int'(vq[i].mis));
            check("expected",   i, int'(a_exp), int'(vq[i].ex));
            check("err_count",  i, int'(a_err), vq[i].err);
            check("chk_count",  i, int'(a_chk), vq[i].chk);
            check("err_sticky", i, int'(a_stk), int'(vq[i].stk));
            check("halted",     i, int'(a_hlt), int'(vq[i].hlt));
            check("first_got",  i, int'(a_fg),  int'(vq[i].fg));
            check("first_exp",  i, int'(a_fe),  int'(vq[i].fe));
        end

        // narrow counters with halting disabled: both saturate at 3
        step(1, 0, 0);
        check("b_reset_err", 0, int'(b_err), 0);
        check("b_reset_stk", 0, int'(b_stk), 0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 2);
            check("b_mismatch", i, int'(b_mis), 1);
            check("b_err_count", i, int'(b_err), (i < 3) ? i : 3);
            check("b_chk_count", i, int'(b_chk), (i < 3) ? i : 3);
            check("b_sticky", i, int'(b_stk), 1);
            check("b_halted", i, int'(b_hlt), 0);
            check("b_first_got", i, int'(b_fg), 2);
            check("b_first_exp", i, int'(b_fe), 0);
            check("b_expected", i, int'(b_exp), 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
